// File: rtl/noc_arb2_merge.sv
// rtl/noc_arb2_merge.sv - two-input round-robin packet merge with grant tag and counters
// Each packet is announced by its grant tag on S before the flit itself goes out on Out.
module noc_arb2_merge #(
  parameter int W    = 9,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            _RESET,
  input  logic [W-1:0]    In0_data,
  input  logic            In0_valid,
  output logic            In0_ready,
  input  logic [W-1:0]    In1_data,
  input  logic            In1_valid,
  output logic            In1_ready,
  output logic            S_data,
  output logic            S_valid,
  input  logic            S_ready,
  output logic [W-1:0]    Out_data,
  output logic            Out_valid,
  input  logic            Out_ready,
  output logic [CNTW-1:0] Cnt0,
  output logic [CNTW-1:0] Cnt1
);

  typedef enum logic [1:0] {IDLE, SEND_S, SEND_D} state_t;

  state_t          state_q;
  logic [W-1:0]    hold_q;
  logic            last_q;
  logic [CNTW-1:0] cnt0_q, cnt1_q;
  logic [CNTW-1:0] cnt0_d, cnt1_d;
  logic            s_valid_q, s_data_q;
  logic            out_valid_q;
  logic [W-1:0]    out_data_q;
  logic            gnt0, gnt1, idle;

  // On contention the input that did not win last time gets the grant.
  always_comb begin
    gnt0   = In0_valid && (!In1_valid || last_q);
    gnt1   = In1_valid && (!In0_valid || !last_q);
    idle   = (state_q == IDLE) && !_RESET;
    cnt0_d = (cnt0_q == {CNTW{1'b1}}) ? cnt0_q : cnt0_q + CNTW'(1);
    cnt1_d = (cnt1_q == {CNTW{1'b1}}) ? cnt1_q : cnt1_q + CNTW'(1);
  end

  assign In0_ready = idle && gnt0;
  assign In1_ready = idle && gnt1;
  assign S_valid   = s_valid_q;
  assign S_data    = s_data_q;
  assign Out_valid = out_valid_q;
  assign Out_data  = out_data_q;
  assign Cnt0      = cnt0_q;
  assign Cnt1      = cnt1_q;

  always_ff @(posedge CLK or posedge _RESET) begin
    if (_RESET) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      last_q      <= 1'b1;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      s_valid_q   <= 1'b0;
      s_data_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (In0_ready || In1_ready) begin
            hold_q    <= In1_ready ? In1_data : In0_data;
            last_q    <= In1_ready;
            s_data_q  <= In1_ready;
            s_valid_q <= 1'b1;
            if (In1_ready) cnt1_q <= cnt1_d;
            else           cnt0_q <= cnt0_d;
            state_q   <= SEND_S;
          end
        end
        SEND_S: begin
          if (S_ready) begin
            s_valid_q   <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= hold_q;
            state_q     <= SEND_D;
          end
        end
        SEND_D: begin
          if (Out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          s_valid_q   <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_arb2_merge.sv
// tb/tb_noc_arb2_merge.sv - randomized and directed bench for noc_arb2_merge
// A packet-level model (one pending packet, tag-sent flag) predicts every cycle.
module tb_noc_arb2_merge;

  logic       CLK = 1'b0;
  logic       _RESET;
  logic [8:0] In0_data, In1_data;
  logic       In0_valid, In1_valid, S_ready, Out_ready;
  logic       In0_ready, In1_ready, S_data, S_valid, Out_valid;
  logic [8:0] Out_data;
  logic [15:0] Cnt0, Cnt1;
  logic       sr0, sr1, ssd, ssv, sov;
  logic [8:0] sod;
  logic [2:0] sc0, sc1;

  always #5 CLK = ~CLK;

  noc_arb2_merge u_dut (
    .CLK(CLK), ._RESET(_RESET),
    .In0_data(In0_data), .In0_valid(In0_valid), .In0_ready(In0_ready),
    .In1_data(In1_data), .In1_valid(In1_valid), .In1_ready(In1_ready),
    .S_data(S_data), .S_valid(S_valid), .S_ready(S_ready),
    .Out_data(Out_data), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Cnt0(Cnt0), .Cnt1(Cnt1)
  );

  noc_arb2_merge #(.W(9), .CNTW(3)) u_sat (
    .CLK(CLK), ._RESET(_RESET),
    .In0_data(In0_data), .In0_valid(In0_valid), .In0_ready(sr0),
    .In1_data(In1_data), .In1_valid(In1_valid), .In1_ready(sr1),
    .S_data(ssd), .S_valid(ssv), .S_ready(S_ready),
    .Out_data(sod), .Out_valid(sov), .Out_ready(Out_ready),
    .Cnt0(sc0), .Cnt1(sc1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  bit         m_busy, m_tag, m_win, m_last;
  logic [8:0] m_data;
  int         m_c0, m_c1, m_s0, m_s1;
  bit         e_r0, e_r1, acc0, acc1;
  int         n_acc;
  int         sgrants[$];
  logic [8:0] last_out;

  task automatic model_reset();
    m_busy = 0; m_tag = 0; m_win = 0; m_last = 1; m_data = '0;
    m_c0 = 0; m_c1 = 0; m_s0 = 0; m_s1 = 0;
    acc0 = 0; acc1 = 0;
  endtask

  task automatic model_accept(input bit w, input logic [8:0] d);
    m_busy = 1; m_tag = 1; m_win = w; m_data = d; m_last = w;
    if (w) begin
      if (m_c1 < 65535) m_c1++;
      if (m_s1 < 7) m_s1++;
    end else begin
      if (m_c0 < 65535) m_c0++;
      if (m_s0 < 7) m_s0++;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    logic [8:0] d0, d1;
    bit sr, orr;
    #1;
    e_r0 = !m_busy && In0_valid && (!In1_valid || m_last);
    e_r1 = !m_busy && In1_valid && (!In0_valid || !m_last);
    check("in0_ready", In0_ready, e_r0);
    check("in1_ready", In1_ready, e_r1);
    check("s_valid", S_valid, m_busy && m_tag);
    check("out_valid", Out_valid, m_busy && !m_tag);
    if (m_busy && m_tag)  check("s_data", S_data, m_win);
    if (m_busy && !m_tag) check("out_data", Out_data, m_data);
    check("cnt0", Cnt0, m_c0);
    check("cnt1", Cnt1, m_c1);
    check("sat_cnt0", sc0, m_s0);
    check("sat_cnt1", sc1, m_s1);
    check("sat_ready", {sr0, sr1}, {e_r0, e_r1});
    check("sat_valid", {ssv, sov}, {m_busy && m_tag, m_busy && !m_tag});
    if (m_busy && m_tag)  check("sat_s_data", ssd, m_win);
    if (m_busy && !m_tag) check("sat_out_data", sod, m_data);
    if (S_valid && S_ready) sgrants.push_back(int'(S_data));
    if (Out_valid && Out_ready) last_out = Out_data;
    d0 = In0_data; d1 = In1_data; sr = S_ready; orr = Out_ready;
    @(posedge CLK);
    acc0 = e_r0; acc1 = e_r1;
    if (!m_busy) begin
      if (e_r0)      begin model_accept(0, d0); n_acc++; end
      else if (e_r1) begin model_accept(1, d1); n_acc++; end
    end else if (m_tag) begin
      if (sr) m_tag = 0;
    end else if (orr) begin
      m_busy = 0;
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    In0_valid = 0; In1_valid = 0; S_ready = 1; Out_ready = 1;
    _RESET = 1;
    model_reset();
    repeat (2) @(negedge CLK);
    _RESET = 0;
    sgrants.delete();
  endtask

  task automatic drain();
    In0_valid = 0; In1_valid = 0; S_ready = 1; Out_ready = 1;
    repeat (4) step();
  endtask

  task automatic run_packets(input int n, input string tag);
    int start, budget;
    start = n_acc; budget = 0;
    while ((n_acc - start) < n && budget < 100) begin
      step();
      budget++;
    end
    check({tag, "_timeout"}, (n_acc - start) >= n, 1);
  endtask

  task automatic async_reset_check(input string tag);
    #2 _RESET = 1;
    #1;
    check({tag, "_rst_valid"}, {S_valid, Out_valid}, 2'b00);
    check({tag, "_rst_ready"}, {In0_ready, In1_ready}, 2'b00);
    check({tag, "_rst_data"}, {S_data, Out_data}, 10'h000);
    check({tag, "_rst_cnt"}, {Cnt0, Cnt1}, 32'h0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    _RESET = 0;
  endtask

  initial begin
    n_acc = 0; last_out = '0;
    In0_data = '0; In1_data = '0;
    In0_valid = 0; In1_valid = 0; S_ready = 0; Out_ready = 0;
    _RESET = 1;
    model_reset();
    #1;
    check("reset_valid", {S_valid, Out_valid, In0_ready, In1_ready}, 4'b0000);
    check("reset_data", {S_data, Out_data}, 10'h000);
    check("reset_cnt", {Cnt0, Cnt1}, 32'h0);
    @(negedge CLK);
    do_reset();

    // Single packet on In0
    In0_valid = 1; In0_data = 9'h1A5;
    step();
    check("t1_accept", acc0, 1);
    In0_valid = 0;
    drain();
    check("t1_tag", sgrants.size() > 0 ? sgrants[0] : -1, 0);
    check("t1_out", last_out, 9'h1A5);
    check("t1_cnt", {Cnt0, Cnt1}, {16'd1, 16'd0});

    // Continuous contention alternates
    do_reset();
    In0_data = 9'h011; In1_data = 9'h122; In0_valid = 1; In1_valid = 1;
    run_packets(6, "t2");
    drain();
    check("t2_ngrants", sgrants.size(), 6);
    for (int i = 0; i < 6 && i < sgrants.size(); i++) check("t2_grant", sgrants[i], i % 2);
    check("t2_cnt", {Cnt0, Cnt1}, {16'd3, 16'd3});

    // Back-pressure on S then Out
    do_reset();
    S_ready = 0; Out_ready = 0;
    In0_valid = 1; In0_data = 9'h0F3;
    step();
    In0_data = 9'h055; In1_valid = 1; In1_data = 9'h1EE;
    repeat (5) begin
      step();
      check("t3_s_hold", {S_valid, S_data, Out_valid}, 3'b100);
    end
    S_ready = 1;
    step();
    S_ready = 0;
    repeat (4) begin
      step();
      check("t3_out_hold", {Out_valid, Out_data}, {1'b1, 9'h0F3});
    end
    In0_valid = 0; In1_valid = 0; Out_ready = 1;
    step();
    check("t3_out", last_out, 9'h0F3);
    drain();

    // Async reset while holding in SEND_D
    do_reset();
    In0_valid = 1; In0_data = 9'h155; Out_ready = 0;
    step();
    In0_valid = 0;
    step();
    check("t4_in_send_d", Out_valid, 1);
    In0_valid = 1; In1_valid = 1;
    async_reset_check("t4");
    In0_valid = 0; In1_valid = 0; Out_ready = 1;
    sgrants.delete();
    repeat (3) begin
      step();
      check("t4_no_out", Out_valid, 0);
    end
    In0_valid = 1; In1_valid = 1; In0_data = 9'h033; In1_data = 9'h144;
    step();
    check("t4_grant_in0", acc0, 1);
    drain();
    check("t4_tag", sgrants.size() > 0 ? sgrants[0] : -1, 0);
    check("t4_cnt", {Cnt0, Cnt1}, {16'd1, 16'd0});

    // Saturation of the 3-bit counters
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      In1_valid = 1; In1_data = 9'($urandom);
      step();
      In1_valid = 0;
      repeat (3) step();
      check("t5_sat_cnt1", sc1, (k < 7) ? k : 7);
      check("t5_sat_cnt0", sc0, 0);
    end
    check("t5_wide_cnt1", Cnt1, 9);

    // Lone In1, then contention
    do_reset();
    In1_valid = 1; In1_data = 9'h1C3;
    step();
    In1_valid = 0;
    repeat (3) step();
    In0_valid = 1; In1_valid = 1; In0_data = 9'h00A; In1_data = 9'h10B;
    run_packets(2, "t6");
    drain();
    check("t6_ngrants", sgrants.size(), 3);
    for (int i = 0; i < 3 && i < sgrants.size(); i++) check("t6_grant", sgrants[i], (i + 1) % 2);

    // Random traffic with random back-pressure and occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      S_ready   = ($urandom % 4) != 0;
      Out_ready = ($urandom % 4) != 0;
      step();
      if (acc0) In0_valid = $urandom % 2;
      if (acc0 || (!In0_valid && ($urandom % 3) == 0)) begin
        if (!acc0) In0_valid = 1;
        In0_data = 9'($urandom);
      end
      if (acc1) In1_valid = $urandom % 2;
      if (acc1 || (!In1_valid && ($urandom % 3) == 0)) begin
        if (!acc1) In1_valid = 1;
        In1_data = 9'($urandom);
      end
      if (($urandom % 400) == 0) async_reset_check("rnd");
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
